miriscv_int_ctrl: RTL and testbench
===================================

Name: miriscv_int_ctrl

Overview:
Interrupt controller directly upstream of the machine CSR file. It scans masked interrupt requests round-robin and selects one. It raises a one-cycle interrupt strobe, which drives CSR opcode bit 2 and the PC redirect to mtvec, together with the cause code for mcause. It holds off further interrupts until the handler's mret (int_fin_i), then returns a one-hot acknowledge to the requesting device.

Parameters:
NUM_IRQ, 32, number of interrupt lines; legal range 2..32; lines at and above NUM_IRQ are ignored.
CNT_W, 5, width of the scan index; must satisfy 2**CNT_W >= NUM_IRQ.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
mie_i  input  32  interrupt enable mask from the CSR mie register; bit k enables line k.
int_req_i  input  32  level-sensitive interrupt requests from peripherals; bit k is line k.
int_fin_i  input  1  handler-complete strobe from the decoder (mret executed); 1 cycle.
int_o  output  1  interrupt taken; 1-cycle pulse to CSR opcode bit 2 and the PC mux.
mcause_o  output  32  cause code for mcause; valid while int_o=1 and held until the next take.
int_rst_o  output  32  one-hot acknowledge to the serviced device; 1-cycle pulse.

Behaviour:
- All outputs are registered. Reset (reset=0, asynchronous): state=SCAN, cnt=0, int_o=0, mcause_o=0, int_rst_o=0.
- FSM states are SCAN, TAKE, WAIT and ACK.
- SCAN: each cycle, hit = int_req_i[cnt] & mie_i[cnt].
  - If hit=1: latch cur=cnt, go to TAKE, set int_o<=1 and mcause_o<={1'b1, 26'b0, cnt zero-extended to 5 bits}.
  - If hit=0: cnt <= (cnt==NUM_IRQ-1) ? 0 : cnt+1.
- TAKE: lasts exactly 1 cycle with int_o=1. Next state is WAIT; int_o<=0; cnt does not move.
- WAIT: int_o=0 and no further takes, regardless of requests or mie.
  - int_fin_i=1 moves to ACK with int_rst_o<=(1<<cur).
  - int_fin_i=0 stays in WAIT.
- ACK: int_rst_o is one-hot for exactly 1 cycle. Next state is SCAN with int_rst_o<=0 and cnt<=cur+1, wrapping at NUM_IRQ. This gives round-robin fairness: the serviced line is scanned last next time.
- Latency: a request on line k, enabled, observed while cnt=c in SCAN produces int_o high ((k-c) mod NUM_IRQ)+1 cycles later. Worst case is NUM_IRQ cycles.
- int_fin_i in SCAN, TAKE or ACK is ignored, with no state change.
- A request deasserted or mie bit cleared after selection does not cancel: TAKE, WAIT and ACK still complete for cur.
- A request held high after ACK is rescanned normally. It is re-taken only when the scan reaches it again, at the earliest NUM_IRQ cycles after ACK if no other line is pending.
- mie_i bit 0 for a line: that line is never taken, whatever int_req_i does.
- Lines k >= NUM_IRQ: never taken, and cnt never reaches them.
- mcause_o keeps its last value outside TAKE. The CSR samples it only when int_o=1.
- Reset asserted in any state returns to SCAN, cnt=0 immediately; any pending acknowledge is lost. Release is synchronous to the next clk edge.
- No combinational path from any input to any output.

Test Plan:
1. Reset release, mie_i=0xFFFFFFFF, int_req_i=0x00000008 at cnt=0 -> int_o pulses 1 cycle, 4 cycles after first edge; mcause_o=0x80000003. Then int_fin_i pulse -> int_rst_o=0x00000008 for exactly 1 cycle on the next cycle.
2. mie_i=0x00000000, int_req_i=0xFFFFFFFF for 100 cycles -> int_o stays 0 and int_rst_o stays 0. Then set mie_i=0x00000020 -> take with mcause_o=0x80000005.
3. Round robin: int_req_i=0x00000011 held, mie_i all ones, and int_fin_i returned 3 cycles after each int_o -> causes alternate 0x80000000, 0x80000004, 0x80000000, ...; int_rst_o alternates 0x1 and 0x10.
4. Hold-off: after the take of line 2, raise int_req_i bit 7 and keep int_fin_i=0 for 50 cycles -> no second int_o. After int_fin_i, line 7 is taken with mcause 0x80000007.
5. Corner cases: int_fin_i pulsed while in SCAN is ignored. Request dropped during WAIT still gets its ack. Reset asserted during WAIT clears outputs asynchronously, and no int_rst_o ever follows.
6. NUM_IRQ=5: int_req_i=0xFFFFFFE0 is never taken. Scan wraps 4->0, and a request on line 0 at cnt=4 gives int_o 2 cycles later.

Source files
------------

// File: rtl/miriscv_int_ctrl.sv
// Round-robin interrupt controller feeding the machine CSR file.
// Takes one masked request, holds off until mret, then acknowledges the device.
module miriscv_int_ctrl #(
    parameter int unsigned NUM_IRQ = 32,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mie_i,
    input  logic [31:0] int_req_i,
    input  logic        int_fin_i,
    output logic        int_o,
    output logic [31:0] mcause_o,
    output logic [31:0] int_rst_o
);

    typedef enum logic [1:0] {
        SCAN,
        TAKE,
        WAIT,
        ACK
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_IRQ - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cur_d;
    logic             hit;

    assign hit = int_req_i[5'(cnt_q)] & mie_i[5'(cnt_q)];

    // Wrapping at NUM_IRQ keeps the scan off lines that do not exist.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        cur_d = (cur_q == LAST) ? '0 : cur_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            cnt_q     <= '0;
            cur_q     <= '0;
            int_o     <= 1'b0;
            mcause_o  <= '0;
            int_rst_o <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        cur_q    <= cnt_q;
                        state_q  <= TAKE;
                        int_o    <= 1'b1;
                        mcause_o <= {1'b1, 26'b0, 5'(cnt_q)};
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                TAKE: begin
                    int_o   <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (int_fin_i) begin
                        int_rst_o <= 32'h1 << cur_q;
                        state_q   <= ACK;
                    end
                end
                ACK: begin
                    // Resume just past the serviced line so it is scanned last.
                    int_rst_o <= '0;
                    cnt_q     <= cur_d;
                    state_q   <= SCAN;
                end
                default: state_q <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Bench for miriscv_int_ctrl: a 32-line and a 5-line instance checked every
// cycle against a service-level reference model, plus directed latency checks.
module tb_miriscv_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mie0, req0, mie1, req1;
    logic        fin0, fin1;
    logic        int0, int1;
    logic [31:0] cause0, cause1, rst0, rst1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    miriscv_int_ctrl #(.NUM_IRQ(32), .CNT_W(5)) dut32 (
        .clk(clk), .reset(reset), .mie_i(mie0), .int_req_i(req0), .int_fin_i(fin0),
        .int_o(int0), .mcause_o(cause0), .int_rst_o(rst0)
    );

    miriscv_int_ctrl #(.NUM_IRQ(5), .CNT_W(3)) dut5 (
        .clk(clk), .reset(reset), .mie_i(mie1), .int_req_i(req1), .int_fin_i(fin1),
        .int_o(int1), .mcause_o(cause1), .int_rst_o(rst1)
    );

    // Reference model: next line to look at, line in service (-1 if idle),
    // and the outputs the controller must be showing.
    int          nirq [2] = '{32, 5};
    int          m_ptr [2];
    int          m_srv [2];
    bit          e_int [2];
    logic [31:0] e_cause [2];
    logic [31:0] e_rst [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i]   = 0;
            m_srv[i]   = -1;
            e_int[i]   = 1'b0;
            e_cause[i] = 32'h0;
            e_rst[i]   = 32'h0;
        end
    endtask

    task automatic model_step(input int i, input logic [31:0] mie, input logic [31:0] req,
                              input logic fin);
        if (e_rst[i] != 32'h0) begin
            e_rst[i] = 32'h0;
            m_ptr[i] = (m_srv[i] + 1) % nirq[i];
            m_srv[i] = -1;
        end else if (e_int[i]) begin
            e_int[i] = 1'b0;
        end else if (m_srv[i] >= 0) begin
            if (fin) e_rst[i] = 32'h1 << m_srv[i];
        end else if (req[m_ptr[i]] && mie[m_ptr[i]]) begin
            m_srv[i]   = m_ptr[i];
            e_int[i]   = 1'b1;
            e_cause[i] = 32'h8000_0000 | 32'(m_ptr[i]);
        end else begin
            m_ptr[i] = (m_ptr[i] + 1) % nirq[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("int_o_32",     {31'b0, int0}, {31'b0, e_int[0]});
        chk("mcause_o_32",  cause0, e_cause[0]);
        chk("int_rst_o_32", rst0, e_rst[0]);
        chk("int_o_5",      {31'b0, int1}, {31'b0, e_int[1]});
        chk("mcause_o_5",   cause1, e_cause[1]);
        chk("int_rst_o_5",  rst1, e_rst[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            model_step(0, mie0, req0, fin0);
            model_step(1, mie1, req1, fin1);
        end
        #1;
        chk_outputs();
    endtask

    task automatic wait_int(input int i, input int bound, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (((i == 0) ? int0 : int1) !== 1'b1 && cyc < bound);
        chk("take_within_bound", {31'b0, (i == 0) ? int0 : int1}, 32'h1);
    endtask

    task automatic fin_pulse(input int i);
        if (i == 0) fin0 = 1'b1; else fin1 = 1'b1;
        tick();
        fin0 = 1'b0;
        fin1 = 1'b0;
    endtask

    task automatic async_reset_check();
        reset = 1'b0;
        #1;
        model_reset();
        chk_outputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int seen;
        logic [31:0] exp_cause;
        logic [31:0] exp_ack;

        reset = 1'b0;
        mie0 = '0; req0 = '0; fin0 = 1'b0;
        mie1 = '0; req1 = '0; fin1 = 1'b0;
        model_reset();
        #2;
        chk_outputs();
        tick();
        tick();
        reset = 1'b1;

        // 1: line 3 from cnt=0 -> take after 4 edges, ack one cycle after mret
        mie0 = 32'hFFFF_FFFF;
        req0 = 32'h0000_0008;
        wait_int(0, 40, cyc);
        chk("latency_line3", 32'(cyc), 32'd4);
        chk("cause_line3", cause0, 32'h8000_0003);
        tick();
        chk("take_one_cycle", {31'b0, int0}, 32'h0);
        req0 = '0;
        tick();
        fin_pulse(0);
        chk("ack_line3", rst0, 32'h0000_0008);
        tick();
        chk("ack_one_cycle", rst0, 32'h0);

        // 2: everything masked, then enable line 5 only
        mie0 = 32'h0;
        req0 = 32'hFFFF_FFFF;
        seen = 0;
        repeat (100) begin
            tick();
            if (int0 || rst0 != 0) seen++;
        end
        chk("masked_no_activity", 32'(seen), 32'd0);
        mie0 = 32'h0000_0020;
        wait_int(0, 40, cyc);
        chk("cause_line5", cause0, 32'h8000_0005);
        repeat (2) tick();
        fin_pulse(0);
        chk("ack_line5", rst0, 32'h0000_0020);
        tick();

        // 3: round robin between lines 0 and 4
        mie0 = 32'hFFFF_FFFF;
        req0 = 32'h0000_0011;
        for (int n = 0; n < 4; n++) begin
            exp_cause = (n % 2 == 0) ? 32'h8000_0000 : 32'h8000_0004;
            exp_ack   = (n % 2 == 0) ? 32'h0000_0001 : 32'h0000_0010;
            wait_int(0, 40, cyc);
            chk("rr_cause", cause0, exp_cause);
            repeat (2) tick();
            fin_pulse(0);
            chk("rr_ack", rst0, exp_ack);
            tick();
        end

        // 4: hold-off while the handler of line 2 runs
        req0 = 32'h0000_0004;
        wait_int(0, 40, cyc);
        chk("cause_line2", cause0, 32'h8000_0002);
        req0 = 32'h0000_0080;
        seen = 0;
        repeat (50) begin
            tick();
            if (int0) seen++;
        end
        chk("holdoff_no_take", 32'(seen), 32'd0);
        fin_pulse(0);
        chk("ack_line2", rst0, 32'h0000_0004);
        wait_int(0, 40, cyc);
        chk("cause_line7", cause0, 32'h8000_0007);
        req0 = '0;
        repeat (2) tick();
        fin_pulse(0);
        chk("ack_line7", rst0, 32'h0000_0080);
        tick();

        // 5a: mret while scanning is ignored
        repeat (3) tick();
        fin_pulse(0);
        chk("fin_in_scan_ignored", rst0, 32'h0);
        // 5b: request dropped during WAIT still acknowledged
        req0 = 32'h0000_0200;
        wait_int(0, 40, cyc);
        req0 = '0;
        mie0 = '0;
        repeat (3) tick();
        fin_pulse(0);
        chk("ack_after_drop", rst0, 32'h0000_0200);
        tick();
        mie0 = 32'hFFFF_FFFF;
        // 5c: reset during WAIT clears state; no ack afterwards
        req0 = 32'h0000_1000;
        wait_int(0, 40, cyc);
        chk("cause_line12", cause0, 32'h8000_000C);
        req0 = '0;
        tick();
        async_reset_check();
        fin0 = 1'b1;
        tick();
        fin0 = 1'b0;
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (rst0 != 0) seen++;
        end
        chk("no_ack_after_reset", 32'(seen), 32'd0);

        // 6: 5-line instance ignores lines 5..31 and wraps 4 -> 0
        mie1 = 32'hFFFF_FFFF;
        req1 = 32'hFFFF_FFE0;
        seen = 0;
        repeat (40) begin
            tick();
            if (int1) seen++;
        end
        chk("high_lines_never_taken", 32'(seen), 32'd0);
        cyc = 0;
        while (m_ptr[1] != 4 && cyc < 10) begin
            tick();
            cyc++;
        end
        req1 = 32'hFFFF_FFE1;
        wait_int(1, 10, cyc);
        chk("wrap_latency", 32'(cyc), 32'd2);
        chk("cause_wrap_line0", cause1, 32'h8000_0000);
        repeat (2) tick();
        fin_pulse(1);
        chk("ack_wrap_line0", rst1, 32'h0000_0001);
        tick();

        // Random traffic on both instances against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req0 = $urandom & $urandom & $urandom;
                req1 = $urandom & $urandom;
            end
            if ($urandom_range(0, 15) == 0) begin
                mie0 = ~($urandom & $urandom & $urandom);
                mie1 = ~($urandom & $urandom);
            end
            fin0 = ($urandom_range(0, 5) == 0);
            fin1 = ($urandom_range(0, 5) == 0);
            if (n == 1500) begin
                #2;
                async_reset_check();
                tick();
                reset = 1'b1;
            end
            tick();
        end
        fin0 = 1'b0;
        fin1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
